// File: rtl/factorial_sched_pkg.sv
// Shared integer types, scheduler state encoding and constants for factorial_sched.
package int_types;

   typedef logic [3:0]  INT04_t;
   typedef logic [40:0] INT41_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      BUSY,
      ACK
   } fact_sched_state_t;

   localparam INT41_t FACT_ONE = 41'd1;

endpackage

// File: rtl/factorial_sched_if.sv
// Requester and engine signals of factorial_sched; master = scheduler side, slave = clients/engine side.
interface factorial_sched_if #(
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]                    req;
   int_types::INT04_t [NREQ-1:0]       req_operand;
   logic [NREQ-1:0]                    gnt;
   logic                               rsp_valid;
   logic [IDW-1:0]                     rsp_id;
   int_types::INT41_t                  rsp_product;
   logic                               rsp_err;
   logic                               load;
   int_types::INT04_t                  operand;
   logic                               done;
   logic                               dack;
   int_types::INT41_t                  product;

   modport master (
      input  req, req_operand, done, product,
      output gnt, rsp_valid, rsp_id, rsp_product, rsp_err, load, operand, dack
   );

   modport slave (
      output req, req_operand, done, product,
      input  gnt, rsp_valid, rsp_id, rsp_product, rsp_err, load, operand, dack
   );

endinterface

// File: rtl/factorial_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           any_req,
   output logic [IDW-1:0] id
);

   logic [N-1:0]   rot;
   logic [IDW-1:0] idx [N];

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_rot
         assign idx[gi] = IDW'((32'(ptr) + 32'(gi)) % N);
         assign rot[gi] = req[idx[gi]];
      end
   endgenerate

   // Walk from the far end so the lowest rotated offset wins.
   always_comb begin
      any_req = |req;
      id      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) id = idx[k];
      end
   end

endmodule

// File: rtl/factorial_sched.sv
// Round-robin scheduler sharing one factorial engine between NREQ requesters.
// Optional macro FACT_SCHED_BYPASS_EN: operands 0 and 1 answer 1 without touching the engine.
module factorial_sched
   import int_types::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   factorial_sched_if.master  bus
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(TIMEOUT + 1);

   fact_sched_state_t state_reg;
   logic [IDW-1:0]    ptr_reg;
   logic [IDW-1:0]    id_reg;
   logic [CW-1:0]     cnt_reg;
   logic [CW-1:0]     cnt_next;
   logic              byp_reg;
   logic              bypass_sel;
   logic              arb_any;
   logic [IDW-1:0]    arb_id;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req     (bus.req),
      .ptr     (ptr_reg),
      .any_req (arb_any),
      .id      (arb_id)
   );

`ifdef FACT_SCHED_BYPASS_EN
   assign bypass_sel = (bus.req_operand[arb_id] <= 4'd1);
`else
   assign bypass_sel = 1'b0;
`endif

   assign cnt_next = cnt_reg + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         ptr_reg         <= '0;
         id_reg          <= '0;
         cnt_reg         <= '0;
         byp_reg         <= 1'b0;
         bus.gnt         <= '0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_id      <= '0;
         bus.rsp_product <= '0;
         bus.rsp_err     <= 1'b0;
         bus.load        <= 1'b0;
         bus.operand     <= '0;
         bus.dack        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (arb_any) begin
                  id_reg      <= arb_id;
                  byp_reg     <= bypass_sel;
                  bus.operand <= bus.req_operand[arb_id];
                  bus.load    <= !bypass_sel;
                  bus.gnt     <= NREQ'(1) << arb_id;
                  state_reg   <= LOAD;
               end
            end
            LOAD: begin
               bus.load <= 1'b0;
               bus.gnt  <= '0;
               cnt_reg  <= '0;
               if (byp_reg) begin
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_id      <= id_reg;
                  bus.rsp_product <= FACT_ONE;
                  bus.rsp_err     <= 1'b0;
                  state_reg       <= ACK;
               end else begin
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
               cnt_reg <= cnt_next;
               if (bus.done) begin
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_id      <= id_reg;
                  bus.rsp_product <= bus.product;
                  bus.rsp_err     <= 1'b0;
                  bus.dack        <= 1'b1;
                  state_reg       <= ACK;
               end else if (cnt_next == CW'(TIMEOUT - 1)) begin
                  // Abort: answer with an error and leave the engine unacknowledged.
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_id      <= id_reg;
                  bus.rsp_product <= '0;
                  bus.rsp_err     <= 1'b1;
                  state_reg       <= ACK;
               end
            end
            ACK: begin
               bus.rsp_valid   <= 1'b0;
               bus.rsp_product <= '0;
               bus.rsp_err     <= 1'b0;
               bus.dack        <= 1'b0;
               ptr_reg         <= (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
               state_reg       <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_factorial_sched.sv
// Self-checking bench for factorial_sched: directed vectors, corner sequences and randomized batches.
`timescale 1ns/1ps
module tb_factorial_sched;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;
`ifdef FACT_SCHED_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   factorial_sched_if #(.NREQ(NREQ)) bus();

   factorial_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          id;
      logic [40:0] prod;
      logic        err;
      int          cyc;
   } rsp_t;

   typedef struct {
      int          id;
      int          op;
      int          dly;
      logic [40:0] exp;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   issue_cnt  [NREQ];
   int   served_cnt [NREQ];
   int   load_cnt = 0, dack_cnt = 0, load_cyc = 0, gnt_cyc = 0;
   int   gnt_q[$];
   rsp_t rsp_q[$];
   int   eng_delay = 3;
   bit   spur = 1'b0;
   int   mdl_ptr = 0;

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         issue_cnt[i]  = 0;
         served_cnt[i] = 0;
      end
   end

   always @(posedge clk) cyc++;

   // A requester holds req until its grant pulse has been seen.
   always_comb begin
      bus.req = '0;
      for (int i = 0; i < NREQ; i++) bus.req[i] = (issue_cnt[i] != served_cnt[i]);
   end

   function automatic logic [63:0] fact(input int n);
      logic [63:0] p = 64'd1;
      for (int k = 2; k <= n; k++) p = p * 64'(k);
      return p;
   endfunction

   // Engine model: done rises dly negedges after load, holds until dack.
   int          eng_cnt = 0;
   bit          eng_busy = 1'b0, eng_done = 1'b0;
   int          eng_op = 0;
   logic [40:0] eng_prod = '0;
   always @(negedge clk) begin
      if (!rst) begin
         eng_busy = 1'b0;
         eng_done = 1'b0;
      end else begin
         if (bus.dack && eng_done) eng_done = 1'b0;
         if (bus.load) begin
            eng_busy = 1'b1;
            eng_cnt  = eng_delay;
            eng_op   = int'(bus.operand);
         end else if (eng_busy && eng_delay >= 0) begin
            eng_cnt--;
            if (eng_cnt <= 0) begin
               eng_done = 1'b1;
               eng_prod = 41'(fact(eng_op));
               eng_busy = 1'b0;
            end
         end
      end
      bus.done    = eng_done | spur;
      bus.product = spur ? 41'd99 : eng_prod;
   end

   always @(negedge clk) begin
      int gid;
      if (rst) begin
         if (bus.gnt != '0) begin
            gid = 99;
            for (int i = 0; i < NREQ; i++) begin
               if (bus.gnt[i]) begin
                  served_cnt[i]++;
                  gid = i;
               end
            end
            if ($countones(bus.gnt) != 1) gid = 99;
            gnt_q.push_back(gid);
            gnt_cyc = cyc;
         end
         if (bus.load) begin
            load_cnt++;
            load_cyc = cyc;
         end
         if (bus.dack) dack_cnt++;
         if (bus.rsp_valid) begin
            rsp_q.push_back('{int'(bus.rsp_id), bus.rsp_product, bus.rsp_err, cyc});
            $display("[TB] rsp id=%0d product=%0d err=%0d cycle=%0d",
                     bus.rsp_id, bus.rsp_product, bus.rsp_err, cyc);
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0d required %0d", nm, act, exp);
      end
   endtask

   function automatic rsp_t get_rsp(input int i);
      rsp_t r;
      r = '{-1, '0, 1'b0, -1};
      if (i < rsp_q.size()) r = rsp_q[i];
      return r;
   endfunction

   function automatic int get_gnt(input int i);
      if (i < gnt_q.size()) return gnt_q[i];
      return -1;
   endfunction

   function automatic int next_id(input logic [NREQ-1:0] mask, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic wait_rsp(input int n, input int budget, input string nm);
      int k = 0;
      while (rsp_q.size() < n && k < budget) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk({nm, "_responses"}, 64'(rsp_q.size()), 64'(n));
   endtask

   task automatic issue(input int id, input int op);
      bus.req_operand[id] = 4'(op);
      issue_cnt[id]++;
   endtask

   task automatic chk_rsp(input string nm, input int idx, input int id, input logic [40:0] prod,
                          input logic err);
      rsp_t r;
      r = get_rsp(idx);
      chk({nm, "_id"}, 64'(r.id), 64'(id));
      chk({nm, "_product"}, 64'(r.prod), 64'(prod));
      chk({nm, "_err"}, 64'(r.err), 64'(err));
   endtask

   initial begin
      vec_t vecs[7];
      int   rb, gb, lb, db, ic, ops[NREQ], exp_ids[$], exp_ops[$], n_eng;
      logic [NREQ-1:0] mask;
      rsp_t r;

      vecs[0] = '{2,  5, 10, 41'd120};
      vecs[1] = '{0, 15,  3, 41'd1307674368000};
      vecs[2] = '{3,  0,  2, 41'd1};
      vecs[3] = '{1,  1,  1, 41'd1};
      vecs[4] = '{3,  7,  5, 41'd5040};
      vecs[5] = '{1, 12,  4, 41'd479001600};
      vecs[6] = '{0, 10,  1, 41'd3628800};

      bus.req_operand = '0;
      #2 rst = 1'b0;
      #1;
      chk("reset_outputs",
          64'({bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err,
               bus.load, bus.operand, bus.dack}), 64'd0);

      // Contention: all four held from reset.
      eng_delay = 3;
      for (int i = 0; i < NREQ; i++) issue(i, i + 3);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wait_rsp(4, 200, "contention");
      for (int i = 0; i < NREQ; i++) chk($sformatf("contention_gnt%0d", i), 64'(get_gnt(i)), 64'(i));
      chk_rsp("contention0", 0, 0, 41'd6, 1'b0);
      chk_rsp("contention1", 1, 1, 41'd24, 1'b0);
      chk_rsp("contention2", 2, 2, 41'd120, 1'b0);
      chk_rsp("contention3", 3, 3, 41'd720, 1'b0);

      // Wrap-around: pointer back at 0 after id 3.
      @(negedge clk);
      rb = rsp_q.size();
      issue(3, 6);
      issue(0, 3);
      wait_rsp(rb + 2, 100, "wrap");
      chk_rsp("wrap_first", rb, 0, 41'd6, 1'b0);
      chk_rsp("wrap_second", rb + 1, 3, 41'd720, 1'b0);

      foreach (vecs[v]) begin
         @(negedge clk);
         rb = rsp_q.size(); gb = gnt_q.size(); lb = load_cnt; db = dack_cnt;
         eng_delay = vecs[v].dly;
         issue(vecs[v].id, vecs[v].op);
         ic = cyc;
         wait_rsp(rb + 1, 100, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_gnt_id", v), 64'(get_gnt(gb)), 64'(vecs[v].id));
         chk($sformatf("vec%0d_gnt_latency", v), 64'(gnt_cyc - ic), 64'd1);
         chk_rsp($sformatf("vec%0d", v), rb, vecs[v].id, vecs[v].exp, 1'b0);
         r = get_rsp(rb);
         if (BYP && vecs[v].op <= 1) begin
            chk($sformatf("vec%0d_rsp_latency", v), 64'(r.cyc - gnt_cyc), 64'd1);
            chk($sformatf("vec%0d_loads", v), 64'(load_cnt - lb), 64'd0);
            chk($sformatf("vec%0d_dacks", v), 64'(dack_cnt - db), 64'd0);
         end else begin
            chk($sformatf("vec%0d_rsp_latency", v), 64'(r.cyc - gnt_cyc), 64'(vecs[v].dly + 1));
            chk($sformatf("vec%0d_loads", v), 64'(load_cnt - lb), 64'd1);
            chk($sformatf("vec%0d_dacks", v), 64'(dack_cnt - db), 64'd1);
         end
      end

      // Timeout: engine never answers.
      @(negedge clk);
      rb = rsp_q.size(); db = dack_cnt;
      eng_delay = -1;
      issue(2, 6);
      wait_rsp(rb + 1, 200, "timeout");
      chk_rsp("timeout", rb, 2, 41'd0, 1'b1);
      r = get_rsp(rb);
      chk("timeout_latency", 64'(r.cyc - load_cyc), 64'(TIMEOUT));
      chk("timeout_dacks", 64'(dack_cnt - db), 64'd0);

      // done outside BUSY is ignored.
      @(negedge clk);
      rb = rsp_q.size(); db = dack_cnt;
      spur = 1'b1;
      repeat (6) @(negedge clk);
      spur = 1'b0;
      repeat (2) @(negedge clk);
      chk("spurious_done_rsp", 64'(rsp_q.size()), 64'(rb));
      chk("spurious_done_dack", 64'(dack_cnt - db), 64'd0);

      // Reset mid-BUSY with the pointer parked at 2.
      eng_delay = 2;
      rb = rsp_q.size();
      issue(1, 4);
      wait_rsp(rb + 1, 100, "pre_reset");
      @(negedge clk);
      eng_delay = -1;
      issue(3, 5);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midbusy_reset_outputs",
          64'({bus.gnt, bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err,
               bus.load, bus.operand, bus.dack}), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      rb = rsp_q.size();
      repeat (80) @(negedge clk);
      chk("midbusy_no_rsp", 64'(rsp_q.size()), 64'(rb));
      eng_delay = 3;
      gb = gnt_q.size();
      issue(1, 2);
      issue(3, 3);
      wait_rsp(rb + 2, 100, "post_reset");
      chk("post_reset_first_gnt", 64'(get_gnt(gb)), 64'd1);
      chk_rsp("post_reset_first", rb, 1, 41'd2, 1'b0);
      chk_rsp("post_reset_second", rb + 1, 3, 41'd6, 1'b0);
      mdl_ptr = 0;

      // Randomized batches against the round-robin reference model.
      for (int b = 0; b < 40; b++) begin
         @(negedge clk);
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         eng_delay = $urandom_range(1, 8);
         rb = rsp_q.size(); lb = load_cnt;
         exp_ids.delete(); exp_ops.delete();
         for (int i = 0; i < NREQ; i++) ops[i] = $urandom_range(0, 15);
         for (int i = 0; i < NREQ; i++) if (mask[i]) issue(i, ops[i]);
         n_eng = 0;
         while (mask != '0) begin
            int id;
            id = next_id(mask, mdl_ptr);
            exp_ids.push_back(id);
            exp_ops.push_back(ops[id]);
            if (!(BYP && ops[id] <= 1)) n_eng++;
            mask[id] = 1'b0;
            mdl_ptr = (id + 1) % NREQ;
         end
         wait_rsp(rb + exp_ids.size(), 300, $sformatf("rand%0d", b));
         foreach (exp_ids[k])
            chk_rsp($sformatf("rand%0d_%0d", b, k), rb + k, exp_ids[k],
                    41'(fact(exp_ops[k])), 1'b0);
         chk($sformatf("rand%0d_loads", b), 64'(load_cnt - lb), 64'(n_eng));
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/factorial_sched.md
Name: factorial_sched

Overview:
- Round-robin scheduler that shares one factorial engine/engine_pgm pair between NREQ requesters.
- Latches one request at a time and issues a one-cycle load with that operand.
- Waits for the engine's done, acknowledges it with dack, and returns the product tagged with the requester id.
- Sits between client blocks and the factorial datapath; drives its load/operand/dack and consumes its done/product.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles in BUSY before the job is aborted with an error response.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req  in  NREQ  per-requester request level; hold high until the matching gnt bit.
- req_operand  in  NREQ x int_types::INT04_t  per-requester operand; must be stable while req is high.
- gnt  out  NREQ  one-hot, one-cycle pulse when the request is accepted.
- rsp_valid  out  1  one-cycle pulse; the response is on rsp_id/rsp_product/rsp_err.
- rsp_id  out  $clog2(NREQ)  requester that owns the response.
- rsp_product  out  int_types::INT41_t  factorial result.
- rsp_err  out  1  response caused by timeout; rsp_product = 0.
- load  out  1  engine load strobe.
- operand  out  int_types::INT04_t  engine operand.
- done  in  1  engine result ready; held high until dack.
- dack  out  1  engine done acknowledge.
- product  in  int_types::INT41_t  engine result.

Behaviour:
- Reset (rst=0, async) state:
  - FSM in IDLE; rr pointer = 0; timeout counter = 0.
  - Outputs gnt, rsp_valid, rsp_id, rsp_product, rsp_err, load, operand and dack are all 0.
- Reset mid-operation: the in-flight job is dropped silently and no response is issued.
- FSM states: IDLE, LOAD, BUSY, ACK. All outputs are registered.
- IDLE:
  - If any req bit is high, choose the first high bit at or after the pointer, wrapping modulo NREQ.
  - Latch the id and req_operand[id], then go to LOAD.
- LOAD (exactly 1 cycle):
  - load=1, operand=latched value, gnt[id]=1.
  - Next state BUSY; timeout counter cleared.
- BUSY:
  - Counter increments each cycle.
  - If done=1, capture product and go to ACK.
  - Else, if counter reaches TIMEOUT-1, set the error flag and go to ACK.
- ACK (exactly 1 cycle):
  - rsp_valid=1, rsp_id=id.
  - Normal completion: dack=1, rsp_product=captured product, rsp_err=0.
  - Timeout: rsp_err=1, rsp_product=0, dack=0.
  - Pointer := (id+1) mod NREQ. Next state IDLE.
- Latency: request sampled in IDLE → load 1 cycle later → response 1 cycle after done is seen.
- Minimum issue interval is 4 cycles per job.
- done while not in BUSY is ignored: no dack, no response.
- A requester whose req stays high after gnt is treated as a new request and competes again under round-robin.
- Simultaneous requests are all served in round-robin order; no requester waits more than NREQ-1 jobs.
- Operand width rule: 4 bits (0..15); 15! fits in the 41-bit product, so no overflow handling.

Optional Feature:
- Macro: FACT_SCHED_BYPASS_EN.
- Defined:
  - Operands 0 and 1 skip the engine entirely; load stays 0.
  - Path is IDLE→LOAD→ACK: gnt pulses in LOAD, rsp_valid pulses the next cycle with rsp_product=1, rsp_err=0, dack=0.
- Undefined: every operand goes through the engine.

Decomposition:
- int_types package:
  - Gains fact_sched_state_t, a 2-bit enum {IDLE, LOAD, BUSY, ACK}.
  - Gains the constant FACT_ONE, the INT41_t value 1.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, pointer.
  - Outputs: any_req and the granted id.
  - Purely combinational; the pointer register stays in factorial_sched.

Test Plan:
- Single job: req[2]=1, operand 5; engine asserts done 10 cycles after load with product 120 → gnt[2] one cycle after req; dack pulses once; rsp_valid with rsp_id=2, rsp_product=120, rsp_err=0.
- Contention: req=4'b1111 with operands 3,4,5,6 held from reset → gnt order 0,1,2,3; responses 6, 24, 120, 720 with matching ids.
- Wrap-around: after id 3 completes, req=4'b1001 → id 0 served before id 3.
- Max operand: operand 15 → rsp_product=1307674368000 (41-bit value, no truncation).
- Timeout: engine never asserts done, TIMEOUT=64 → rsp_valid with rsp_err=1, rsp_product=0 exactly 64 cycles after load; dack stays 0.
- Reset mid-BUSY: rst low while waiting → all outputs 0 immediately (asynchronously), no response after release, next req granted from pointer 0.
- Bypass: with FACT_SCHED_BYPASS_EN, operand 0 → load never asserts, rsp_product=1 one cycle after gnt; without the macro, load asserts and the engine result is returned.
